// File: rtl/uart_tx_port_if.sv
// CPU IO-slot bus for the UART transmit port: write strobe/data in, status word out.
interface uart_tx_port_if;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output WE, WD, input RD);
    modport slave  (input WE, WD, output RD);
endinterface

// File: rtl/uart_tx_port.sv
// UART transmit responder: byte FIFO fed from the IO slot, drained as 8N1 frames on TXD.
// Status word on RD is combinational from registered state only.
module uart_tx_port #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    uart_tx_port_if.slave bus,
    output logic          TXD
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic cmd, push_req, accept, pop, baud_tick, full, empty;
    logic unused_wd;

    assign unused_wd = ^bus.WD[30:8];

    always_comb begin
        cmd       = bus.WE & bus.WD[31];
        push_req  = bus.WE & ~bus.WD[31];
        full      = (level_q == LVL_FULL);
        empty     = (level_q == '0);
        baud_tick = (baud_q == BAUD_LAST);
        pop       = (state_q == IDLE) && !empty;
        // A full FIFO still takes a byte when the head leaves on the same edge.
        accept    = push_req && (!full || pop);
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: if (baud_tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_tick) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (baud_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Line level follows the state one cycle later, straight from a flop.
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (accept) begin
            mem_d[wr_ptr_q] = bus.WD[7:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (accept && !pop)      level_d = level_q + 1'b1;
        else if (!accept && pop) level_d = level_q - 1'b1;
        if (push_req && !accept) ovf_d = 1'b1;
        if (cmd && bus.WD[1])    ovf_d = 1'b0;
        // Flush drops the queue only; a byte already in the shifter still goes out.
        if (cmd && bus.WD[0]) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_comb begin
        bus.RD            = '0;
        bus.RD[LW-1:0]    = level_q;
        bus.RD[8]         = empty;
        bus.RD[9]         = full;
        bus.RD[10]        = (state_q != IDLE);
        bus.RD[11]        = ovf_q;
    end

    assign TXD = txd_q;
endmodule
